// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the pack-FSM state type.
// Consumers: polyvecl_pack_eta and eta_coeff_pack.
package dilithium_pkg;

    // Ring dimension: coefficients per polynomial.
    localparam int N       = 256;
    // Default vector length (polynomials per vector).
    localparam int L       = 5;
    // Default secret coefficient bound.
    localparam int ETA     = 4;
    // Width of one unpacked two's-complement coefficient.
    localparam int COEFF_W = 32;
    // Width of one packed coefficient.
    localparam int NIB_W   = 4;
    // Signed working width for ETA - a.
    // It holds [-2*ETA, 2*ETA] exactly before truncation.
    localparam int CALC_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RTR,
        LOAD,
        PACK,
        DONE
    } pack_state_e;

endpackage

// File: rtl/eta_coeff_pack.sv
// eta_coeff_pack: converts one signed coefficient into its packed nibble.
// The result is (ETA - a) mod 16.
// With PACK_RANGE_CHECK_EN defined, it also flags coefficients outside [-ETA, ETA].
module eta_coeff_pack
    import dilithium_pkg::*;
#(
    parameter int ETA_P = dilithium_pkg::ETA
) (
    input  logic signed [COEFF_W-1:0] coeff,
    output logic [NIB_W-1:0]          nibble
`ifdef PACK_RANGE_CHECK_EN
    ,
    output logic                      out_of_range
`endif
);

    localparam logic signed [CALC_W-1:0] ETA_C = CALC_W'(ETA_P);

    logic signed [CALC_W-1:0] coeff_lo;

    // A mod-16 result depends only on the low bits of the operand.
    // The 6-bit signed subtract is therefore exact for any input.
    assign coeff_lo = coeff[CALC_W-1:0];
    assign nibble   = NIB_W'(ETA_C - coeff_lo);

`ifdef PACK_RANGE_CHECK_EN
    localparam logic signed [COEFF_W-1:0] HI = COEFF_W'(ETA_P);
    localparam logic signed [COEFF_W-1:0] LO = -COEFF_W'(ETA_P);

    // The range test needs the full coefficient.
    // A large value can alias into range in the low bits.
    assign out_of_range = (coeff > HI) || (coeff < LO);
`else
    logic unused_hi;
    assign unused_hi = ^coeff[COEFF_W-1:CALC_W];
`endif

endmodule

// File: rtl/polyvecl_pack_eta.sv
// polyvecl_pack_eta: packs an L-polynomial eta-bounded vector into 4-bit nibbles.
//
// Sequence:
//   IDLE -> WAIT_RTR -> (rtr) -> LOAD -> PACK x (L*256/CPC) -> DONE
//
// LOAD snapshots linear_v, so the input may change freely afterwards.
// PACK converts CPC coefficients per cycle.
// rts is registered and rises one edge after DONE entry.
// DONE is held until rts has been visible for at least one cycle and rtr is low.
// This lets a single-cycle rtr pulse still produce an observable rts.
//
// Optional feature: define PACK_RANGE_CHECK_EN to add the sticky range_err output.
// Legal CPC values are 1, 2, 4, 8 and 16.
module polyvecl_pack_eta
    import dilithium_pkg::*;
#(
    parameter int L   = dilithium_pkg::L,
    parameter int ETA = dilithium_pkg::ETA,
    parameter int CPC = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rtr,
    input  logic signed [L*N*COEFF_W-1:0] linear_v,
    output logic [L*N*NIB_W-1:0]          linear_packed,
    output logic                          rts
`ifdef PACK_RANGE_CHECK_EN
    ,
    output logic                          range_err
`endif
);

    localparam int TOTAL  = L * N;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int CIDX_W = $clog2(TOTAL * COEFF_W);
    localparam int NIDX_W = $clog2(TOTAL * NIB_W);
    localparam int LAST_K = TOTAL - CPC;

    pack_state_e                      state;
    logic [CNT_W-1:0]                 k;
    logic signed [TOTAL*COEFF_W-1:0]  lin_q;

    logic [CIDX_W-1:0]                cbase;
    logic [NIDX_W-1:0]                nbase;
    logic [CPC*COEFF_W-1:0]           coeff_win;
    logic [CPC*NIB_W-1:0]             nib_win;
`ifdef PACK_RANGE_CHECK_EN
    logic [CPC-1:0]                   lane_oor;
`endif

    // The window of CPC coefficients currently being packed.
    // k is cleared on the last PACK cycle, so the select always stays in range.
    assign cbase     = CIDX_W'(k) * CIDX_W'(COEFF_W);
    assign nbase     = NIDX_W'(k) * NIDX_W'(NIB_W);
    assign coeff_win = lin_q[cbase +: CPC*COEFF_W];

    // One combinational converter per lane.
    for (genvar i = 0; i < CPC; i++) begin : g_lane
        eta_coeff_pack #(
            .ETA_P (ETA)
        ) u_pack (
            .coeff        (coeff_win[i*COEFF_W +: COEFF_W]),
            .nibble       (nib_win[i*NIB_W +: NIB_W])
`ifdef PACK_RANGE_CHECK_EN
            ,
            .out_of_range (lane_oor[i])
`endif
        );
    end

    // Control FSM, input snapshot, packed result and handshake output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            k             <= '0;
            lin_q         <= '0;
            linear_packed <= '0;
            rts           <= 1'b0;
`ifdef PACK_RANGE_CHECK_EN
            range_err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= WAIT_RTR;
                end

                WAIT_RTR: begin
                    if (rtr) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    lin_q     <= linear_v;
                    k         <= '0;
`ifdef PACK_RANGE_CHECK_EN
                    range_err <= 1'b0;
`endif
                    state     <= PACK;
                end

                PACK: begin
                    linear_packed[nbase +: CPC*NIB_W] <= nib_win;
`ifdef PACK_RANGE_CHECK_EN
                    if (|lane_oor) begin
                        range_err <= 1'b1;
                    end
`endif
                    if (k == CNT_W'(LAST_K)) begin
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + CNT_W'(CPC);
                    end
                end

                DONE: begin
                    rts <= 1'b1;
                    if (rts && !rtr) begin
                        rts   <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polyvecl_pack_eta.sv
// Self-checking bench for polyvecl_pack_eta.
// Three instances (CPC = 8, 1 and 16) share the stimulus.
// Range-error checks are compiled in only with PACK_RANGE_CHECK_EN.
module tb_polyvecl_pack_eta;
    import dilithium_pkg::*;

    localparam int TOT = L * N;
    localparam int VW  = TOT * COEFF_W;
    localparam int PW  = TOT * NIB_W;

    logic clock = 1'b0;
    logic reset;
    logic rtr;
    logic signed [VW-1:0] linear_v;
    logic [PW-1:0] packed8, packed1, packed16;
    logic rts8, rts1, rts16;
`ifdef PACK_RANGE_CHECK_EN
    logic err8, err1, err16;
`endif

    int n_checks;
    int n_fail;

    typedef struct {
        string      name;
        int         fill;
        int         sp_idx;
        int         sp_val;
        logic [3:0] nib_fill;
        logic [3:0] nib_sp;
        logic       err;
    } vec_t;

    always #5 clock = ~clock;

    polyvecl_pack_eta #(.CPC(8)) u_c8 (
        .clock(clock), .reset(reset), .rtr(rtr), .linear_v(linear_v),
        .linear_packed(packed8), .rts(rts8)
`ifdef PACK_RANGE_CHECK_EN
        , .range_err(err8)
`endif
    );

    polyvecl_pack_eta #(.CPC(1)) u_c1 (
        .clock(clock), .reset(reset), .rtr(rtr), .linear_v(linear_v),
        .linear_packed(packed1), .rts(rts1)
`ifdef PACK_RANGE_CHECK_EN
        , .range_err(err1)
`endif
    );

    polyvecl_pack_eta #(.CPC(16)) u_c16 (
        .clock(clock), .reset(reset), .rtr(rtr), .linear_v(linear_v),
        .linear_packed(packed16), .rts(rts16)
`ifdef PACK_RANGE_CHECK_EN
        , .range_err(err16)
`endif
    );

    function automatic int cpc_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 1 : 16;
    endfunction

    function automatic logic rts_of(input int d);
        return (d == 0) ? rts8 : (d == 1) ? rts1 : rts16;
    endfunction

    function automatic logic [PW-1:0] pk_of(input int d);
        return (d == 0) ? packed8 : (d == 1) ? packed1 : packed16;
    endfunction

`ifdef PACK_RANGE_CHECK_EN
    function automatic logic err_of(input int d);
        return (d == 0) ? err8 : (d == 1) ? err1 : err16;
    endfunction
`endif

    // Reference polyeta_pack: nibble = (ETA - a) mod 16, using a mathematical modulo.
    function automatic logic [PW-1:0] model_pack(input logic [VW-1:0] v);
        logic [PW-1:0] r;
        longint a, m;
        r = '0;
        for (int i = 0; i < TOT; i++) begin
            a = longint'($signed(v[i*32 +: 32]));
            m = ((longint'(ETA) - a) % 16 + 16) % 16;
            r[i*4 +: 4] = 4'(m);
        end
        return r;
    endfunction

    function automatic logic model_err(input logic [VW-1:0] v);
        longint a;
        for (int i = 0; i < TOT; i++) begin
            a = longint'($signed(v[i*32 +: 32]));
            if (a < -longint'(ETA) || a > longint'(ETA)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_vec(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        int idx;
        idx = 0;
        n_checks++;
        if (act !== exp) begin
            for (int i = TOT - 1; i >= 0; i--) begin
                if (act[i*4 +: 4] !== exp[i*4 +: 4]) idx = i;
            end
            n_fail++;
            $display("FAIL %s: first bad nibble %0d got %h expected %h",
                     nm, idx, act[idx*4 +: 4], exp[idx*4 +: 4]);
        end
    endtask

    // Pulses rtr for one edge, then scrambles linear_v after the capture.
    // Checks each instance's latency, packed output (and range flag) at rts rise,
    // and that each instance returns to idle.
    task automatic do_run(input logic [VW-1:0] v, input logic [PW-1:0] exp,
                          input logic exp_err, input string nm);
        int lat [3];
        int cnt;
        linear_v = v;
        @(negedge clock);
        rtr = 1'b1;
        @(posedge clock);
        #1 rtr = 1'b0;
        lat = '{-1, -1, -1};
        cnt = 0;
        while (cnt < 1400 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0)) begin
            @(posedge clock);
            cnt++;
            if (cnt == 3) begin
                for (int i = 0; i < TOT; i++) linear_v[i*32 +: 32] = $urandom();
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                if (lat[d] < 0 && rts_of(d)) begin
                    lat[d] = cnt;
                    check_vec($sformatf("%s/cpc%0d packed", nm, cpc_of(d)), pk_of(d), exp);
`ifdef PACK_RANGE_CHECK_EN
                    check($sformatf("%s/cpc%0d range_err", nm, cpc_of(d)), err_of(d), exp_err);
`endif
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s/cpc%0d latency", nm, cpc_of(d)), lat[d], 2 + TOT / cpc_of(d));
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s/cpc%0d rts_idle", nm, cpc_of(d)), rts_of(d), 0);
        end
        if (exp_err === 1'bx) $display("note: unknown expected flag");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          tbl [8];
        logic [VW-1:0] v;
        logic [PW-1:0] e;
        int            c;
        int            cnt;
        int            bad;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        rtr      = 1'b0;
        linear_v = '0;

        tbl[0] = '{"zeros",     0,           -1,  0, 4'h4, 4'h0, 1'b0};
        tbl[1] = '{"all_m4",    -4,          -1,  0, 4'h8, 4'h0, 1'b0};
        tbl[2] = '{"all_p4",    4,           -1,  0, 4'h0, 4'h0, 1'b0};
        tbl[3] = '{"p2c255_m3", 0,          767, -3, 4'h4, 4'h7, 1'b0};
        tbl[4] = '{"p0c7_5",    0,            7,  5, 4'h4, 4'hf, 1'b1};
        tbl[5] = '{"all_m1",    -1,          -1,  0, 4'h5, 4'h0, 1'b0};
        tbl[6] = '{"all_maxpos", 32'h7fffffff, -1, 0, 4'h5, 4'h0, 1'b1};
        tbl[7] = '{"maxneg_end", 32'h80000000, 1279, 3, 4'h4, 4'h1, 1'b1};

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset/cpc%0d rts", cpc_of(d)), rts_of(d), 0);
            check_vec($sformatf("reset/cpc%0d packed", cpc_of(d)), pk_of(d), '0);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // Directed table.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < TOT; i++) begin
                v[i*32 +: 32] = tbl[t].fill;
                e[i*4 +: 4]   = tbl[t].nib_fill;
            end
            if (tbl[t].sp_idx >= 0) begin
                v[tbl[t].sp_idx*32 +: 32] = tbl[t].sp_val;
                e[tbl[t].sp_idx*4 +: 4]   = tbl[t].nib_sp;
            end
            do_run(v, e, tbl[t].err, tbl[t].name);
        end

        // Random vectors against the model.
        // The later runs sprinkle full-range coefficients.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < TOT; i++) begin
                if (r >= 2 && $urandom_range(0, 49) == 0) begin
                    v[i*32 +: 32] = $urandom();
                end else begin
                    c = int'($urandom_range(0, 8)) - 4;
                    v[i*32 +: 32] = c;
                end
            end
            do_run(v, model_pack(v), model_err(v), $sformatf("rand%0d", r));
        end

        // Reset asserted around PACK cycle 50.
        for (int i = 0; i < TOT; i++) begin
            c = int'($urandom_range(0, 8)) - 4;
            v[i*32 +: 32] = c;
        end
        linear_v = v;
        @(negedge clock);
        rtr = 1'b1;
        @(posedge clock);
        #1 rtr = 1'b0;
        repeat (50) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("midreset/cpc%0d rts", cpc_of(d)), rts_of(d), 0);
            check_vec($sformatf("midreset/cpc%0d packed", cpc_of(d)), pk_of(d), '0);
`ifdef PACK_RANGE_CHECK_EN
            check($sformatf("midreset/cpc%0d range_err", cpc_of(d)), err_of(d), 0);
`endif
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        do_run(v, model_pack(v), 1'b0, "after_reset");

        // Hold rtr high while in DONE, then drop it.
        for (int i = 0; i < TOT; i++) begin
            c = int'($urandom_range(0, 8)) - 4;
            v[i*32 +: 32] = c;
        end
        e = model_pack(v);
        linear_v = v;
        @(negedge clock);
        rtr = 1'b1;
        @(posedge clock);
        cnt = 0;
        #1;
        while (cnt < 400 && !rts8) begin
            @(posedge clock);
            cnt++;
            #1;
        end
        check("hold/latency", cnt, 2 + TOT / 8);
        check_vec("hold/packed", packed8, e);
        bad = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (!rts8 || packed8 !== e) bad++;
        end
        check("hold/stable_cycles_bad", bad, 0);
        @(negedge clock);
        rtr = 1'b0;
        @(posedge clock);
        #1;
        check("hold/drop_rtr_rts", rts8, 0);
        check_vec("hold/drop_rtr_packed", packed8, e);
        cnt = 0;
        while (cnt < 1400 && !rts1) begin
            @(posedge clock);
            cnt++;
            #1;
        end
        check("hold/cpc1_done", rts1, 1);
        check_vec("hold/cpc1_packed", packed1, e);
        repeat (3) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/polyvecl_pack_eta.md
POLYVECL_PACK_ETA -- requirements
Module: polyvecl_pack_eta

Interface
REQ-001 SHALL have parameter L, default 5: polynomials per vector.
REQ-002 SHALL have parameter ETA, default 4: secret coefficient bound.
REQ-003 SHALL have parameter CPC, default 8: coefficients packed per cycle; legal values 1, 2, 4, 8, 16.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rtr, input, 1 bit: upstream ready-to-read request.
REQ-007 SHALL have port linear_v, input signed, 40960 bits: L polys x 256 coeffs x 32-bit two's complement. Coefficient j of poly x occupies bits 8192x+32j+31 : 8192x+32j.
REQ-008 SHALL have port linear_packed, output, 5120 bits: packed vector. Nibble j of poly x occupies bits 1024x+4j+3 : 1024x+4j.
REQ-009 SHALL have port rts, output, 1 bit: result ready to send.

Function
REQ-010 SHALL have four states: IDLE, WAIT_RTR, LOAD and PACK, plus a fifth state, DONE.
REQ-011 SHALL go from IDLE to WAIT_RTR unconditionally.
REQ-012 SHALL go from WAIT_RTR to LOAD on the first edge with rtr=1; otherwise it stays in WAIT_RTR.
REQ-013 In LOAD, SHALL capture linear_v into an internal register, clear the coefficient counter to 0, and go to PACK.
REQ-014 In PACK, on each cycle SHALL write nibbles k..k+CPC-1 (flat index across polys, k = counter) with value (ETA - a) mod 16, then advance the counter by CPC.
REQ-015 SHALL leave PACK for DONE after the cycle in which k+CPC = L*256, i.e. after exactly L*256/CPC PACK cycles (160 at defaults).
REQ-016 SHALL hold rts=1 only in DONE; rts SHALL be a registered or state-decoded output with no glitch from rtr.
REQ-017 SHALL stay in DONE while rtr=1 and go to IDLE on the first edge with rtr=0.
REQ-018 SHALL keep linear_packed stable from DONE entry until the next LOAD.
REQ-019 SHALL ignore changes on linear_v after LOAD.
REQ-020 SHALL ignore rtr in LOAD and PACK, including rtr deasserting mid-pack.
REQ-021 Latency: with rtr first sampled high at edge N, rts SHALL rise after edge N+2+L*256/CPC.
REQ-022 SHALL compute the nibble arithmetic in at least 6-bit signed width before truncation to 4 bits.

Reset
REQ-023 reset=0 SHALL immediately force state=IDLE, rts=0, linear_packed=0, counter=0, and clear the captured input, regardless of the current state.
REQ-024 After reset releases mid-operation, the next rtr SHALL start a complete fresh pack with no residue from the aborted run.

Configuration
REQ-025 With PACK_RANGE_CHECK_EN defined, SHALL add output range_err (1 bit, reset 0).
  - range_err clears in LOAD.
  - range_err sets sticky during PACK if any coefficient lies outside [-ETA, ETA].
  - range_err is valid while rts=1.
REQ-026 Without PACK_RANGE_CHECK_EN, SHALL omit the range_err port and pack out-of-range values as (ETA - a) mod 16 with no indication.

Structure
REQ-027 SHALL take N=256, L, ETA, the coefficient width 32 and the packed nibble width 4 from the shared dilithium_pkg package.
REQ-028 SHALL implement the per-coefficient conversion (and, when compiled in, the range flag) in one combinational sub-module eta_coeff_pack, instantiated CPC times.

Verification
REQ-029 All-zero linear_v, rtr pulse: every nibble SHALL be 4 (linear_packed = 0x4444...4), and rts SHALL rise exactly 162 cycles after rtr is sampled.
REQ-030 All coefficients -4: every nibble SHALL be 8. All coefficients +4: every nibble SHALL be 0.
REQ-031 Poly 2 coeff 255 = -3, all others 0: bits 3071:3068 SHALL be 7 and all other nibbles 4. Repeat with CPC=1 and CPC=16 and compare against a software polyeta_pack model.
REQ-032 reset asserted at PACK cycle 50: rts and linear_packed SHALL be 0 immediately; a subsequent run SHALL match the golden output.
REQ-033 Hold rtr=1 for 20 cycles after rts rises: rts SHALL stay 1 and the output stay stable; dropping rtr SHALL take the block back to IDLE on the next edge.
REQ-034 With PACK_RANGE_CHECK_EN, poly 0 coeff 7 = 5: range_err SHALL be 1 at rts. With all coefficients in [-4, 4], the next run SHALL show range_err = 0.
